// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: shared state encoding and default word width for the program loader
package loader_pkg;
  localparam int XLEN_DEF = 32;
  typedef enum logic [2:0] {IDLE, LOAD, HOLD, RUN, ERR} loader_state_t;
endpackage

// File: rtl/imem_loader_if.sv
// imem_loader_if: valid/ready instruction-word stream feeding the loader
interface imem_loader_if
  import loader_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
);
  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] in_data;
  logic            in_last;
  modport master(output in_valid, in_data, in_last, input in_ready);
  modport slave(input in_valid, in_data, in_last, output in_ready);
endinterface

// File: rtl/imem_loader.sv
// imem_loader: streams an instruction image into imem and holds the CPU in reset until it settles
// Optional running checksum of written words when LOADER_CHECKSUM_EN is defined.
module imem_loader
  import loader_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int DEPTH = 256,
  parameter int RESET_HOLD = 4,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  imem_loader_if.slave      s,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [XLEN-1:0]   imem_wdata,
  output logic              load_ins,
  output logic              cpu_reset,
  output logic              done,
  output logic              overflow,
  output logic [ADDR_W:0]   word_count
`ifdef LOADER_CHECKSUM_EN
  ,
  output logic [XLEN-1:0]   checksum
`endif
);
  localparam int HW = $clog2(RESET_HOLD + 1);
  localparam logic [ADDR_W:0] WC_MAX = (ADDR_W + 1)'(DEPTH);
  loader_state_t state;
  logic [HW-1:0] hold_cnt;
  logic rdy;
  logic accept;
  assign s.in_ready = rdy;
  // rdy is only ever high in LOAD, so it alone qualifies the handshake
  assign accept = s.in_valid && rdy;
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      hold_cnt   <= '0;
      rdy        <= 1'b0;
      load_ins   <= 1'b0;
      cpu_reset  <= 1'b1;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      done       <= 1'b0;
      overflow   <= 1'b0;
      word_count <= '0;
`ifdef LOADER_CHECKSUM_EN
      checksum   <= '0;
`endif
    end else begin
      imem_we <= 1'b0;
      case (state)
        IDLE, RUN, ERR: if (start) begin
          state      <= LOAD;
          rdy        <= 1'b1;
          load_ins   <= 1'b1;
          cpu_reset  <= 1'b1;
          done       <= 1'b0;
          overflow   <= 1'b0;
          word_count <= '0;
          hold_cnt   <= '0;
`ifdef LOADER_CHECKSUM_EN
          checksum   <= '0;
`endif
        end
        LOAD: if (accept) begin
          imem_we    <= 1'b1;
          imem_addr  <= word_count[ADDR_W-1:0];
          imem_wdata <= s.in_data;
          word_count <= (word_count == WC_MAX) ? word_count : word_count + 1'b1;
`ifdef LOADER_CHECKSUM_EN
          checksum   <= checksum + s.in_data;
`endif
          if (s.in_last) begin
            state    <= HOLD;
            rdy      <= 1'b0;
            load_ins <= 1'b0;
          end else if (word_count == WC_MAX - 1'b1) begin
            state    <= ERR;
            rdy      <= 1'b0;
            load_ins <= 1'b0;
            overflow <= 1'b1;
          end
        end
        // the final write is visible the cycle HOLD is entered; count from there
        HOLD: if (hold_cnt == HW'(RESET_HOLD - 1)) begin
          state     <= RUN;
          cpu_reset <= 1'b0;
          done      <= 1'b1;
        end else begin
          hold_cnt <= hold_cnt + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: table-driven and randomized image loads checked against a transaction-level model
module tb_imem_loader;
  localparam int DEPTH = 8;
  localparam int HOLD = 4;
  localparam int AW = 3;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic imem_we, load_ins, cpu_reset, done, overflow;
  logic [AW-1:0] imem_addr;
  logic [31:0] imem_wdata;
  logic [AW:0] word_count;
`ifdef LOADER_CHECKSUM_EN
  logic [31:0] checksum;
`endif
  imem_loader_if #(.XLEN(32)) bus ();
  imem_loader #(.XLEN(32), .DEPTH(DEPTH), .RESET_HOLD(HOLD)) dut (
    .clk(clk), .reset(reset), .start(start), .s(bus),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .load_ins(load_ins), .cpu_reset(cpu_reset), .done(done),
    .overflow(overflow), .word_count(word_count)
`ifdef LOADER_CHECKSUM_EN
    , .checksum(checksum)
`endif
  );
  always #5 clk = ~clk;
  typedef struct {int a; logic [31:0] d;} wr_t;
  typedef struct {int kind; int n; int last_at; int pct; bit alt; int exp_wc; bit exp_ovf;} vec_t;
  wr_t wq[$];
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int first_w = 0;
  int last_w = 0;
  int fall_c = 0;
  logic prev_cr = 1'b1;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      if (wq.size() == 0) first_w <= cyc;
      last_w <= cyc;
      wq.push_back('{a: int'(imem_addr), d: imem_wdata});
    end
    if (prev_cr === 1'b1 && cpu_reset === 1'b0) fall_c <= cyc;
    prev_cr <= cpu_reset;
  end
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  // image semantics: completes at in_last unless DEPTH beats arrive first
  function automatic void model(input int last_at, output int wc, output bit ovf);
    ovf = (last_at == 0 || last_at > DEPTH);
    wc = ovf ? DEPTH : last_at;
  endfunction
  task automatic do_load(input vec_t v);
    logic [31:0] img[4];
    logic [31:0] w[$];
    logic [31:0] sum;
    int idx, stall;
    bit rdy, ended;
    img = '{32'h00500093, 32'h00100113, 32'h002081b3, 32'h0000006f};
    for (int i = 0; i < v.n; i++)
      w.push_back(v.kind == 0 ? img[i%4] : v.kind == 1 ? 32'(i + 1) : $urandom());
    @(negedge clk);
    wq.delete();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("start_ovf_clr", {63'b0, overflow}, 64'd0);
    chk("start_load_ins", {63'b0, load_ins}, 64'd1);
    chk("start_ready", {63'b0, bus.in_ready}, 64'd1);
    chk("start_done", {63'b0, done}, 64'd0);
    chk("start_cpu_reset", {63'b0, cpu_reset}, 64'd1);
`ifdef LOADER_CHECKSUM_EN
    chk("start_csum", {32'b0, checksum}, 64'd0);
`endif
    idx = 0;
    stall = 0;
    ended = 1'b0;
    for (int c = 0; c < 300; c++) begin
      bus.in_valid = v.alt ? (c % 2 == 0) : ($urandom_range(99) < v.pct);
      bus.in_data = idx < v.n ? w[idx] : 32'h0;
      bus.in_last = (idx + 1 == v.last_at);
      rdy = bus.in_ready;
      if (!rdy) stall++;
      if (stall >= 3 || idx >= v.n) begin
        ended = 1'b1;
        break;
      end
      @(negedge clk);
      if (bus.in_valid && rdy) begin
        idx++;
        if (bus.in_last) begin
          ended = 1'b1;
          break;
        end
      end
    end
    chk("load_timeout", {63'b0, ended}, 64'd1);
    bus.in_valid = 1'b0;
    bus.in_last = 1'b0;
    repeat (HOLD + 3) @(negedge clk);
    chk("n_writes", 64'(wq.size()), 64'(v.exp_wc));
    sum = '0;
    for (int i = 0; i < v.exp_wc; i++) sum += w[i];
    for (int i = 0; i < wq.size() && i < v.exp_wc; i++) begin
      chk("waddr", 64'(wq[i].a), 64'(i));
      chk("wdata", {32'b0, wq[i].d}, {32'b0, w[i]});
    end
    chk("word_count", 64'(word_count), 64'(v.exp_wc));
    chk("overflow", {63'b0, overflow}, {63'b0, v.exp_ovf});
    chk("cpu_reset", {63'b0, cpu_reset}, {63'b0, v.exp_ovf});
    chk("done", {63'b0, done}, {63'b0, !v.exp_ovf});
    chk("end_ready", {63'b0, bus.in_ready}, 64'd0);
    chk("end_load_ins", {63'b0, load_ins}, 64'd0);
    if (!v.exp_ovf) chk("hold_cycles", 64'(fall_c - last_w), 64'(HOLD));
    if (!v.alt && v.pct == 100) chk("burst", 64'(last_w - first_w), 64'(v.exp_wc - 1));
`ifdef LOADER_CHECKSUM_EN
    chk("checksum", {32'b0, checksum}, {32'b0, sum});
`endif
  endtask
  initial begin
    vec_t tbl[6];
    vec_t r;
    tbl[0] = '{kind: 0, n: 4, last_at: 4, pct: 100, alt: 1'b0, exp_wc: 4, exp_ovf: 1'b0};
    tbl[1] = '{kind: 0, n: 4, last_at: 4, pct: 100, alt: 1'b1, exp_wc: 4, exp_ovf: 1'b0};
    tbl[2] = '{kind: 2, n: 9, last_at: 0, pct: 100, alt: 1'b0, exp_wc: 8, exp_ovf: 1'b1};
    tbl[3] = '{kind: 1, n: 3, last_at: 3, pct: 100, alt: 1'b0, exp_wc: 3, exp_ovf: 1'b0};
    tbl[4] = '{kind: 2, n: 8, last_at: 8, pct: 100, alt: 1'b0, exp_wc: 8, exp_ovf: 1'b0};
    tbl[5] = '{kind: 2, n: 1, last_at: 1, pct: 100, alt: 1'b0, exp_wc: 1, exp_ovf: 1'b0};
    bus.in_valid = 1'b0;
    bus.in_last = 1'b0;
    bus.in_data = '0;
    repeat (2) @(negedge clk);
    chk("rst_cpu_reset", {63'b0, cpu_reset}, 64'd1);
    chk("rst_ready", {63'b0, bus.in_ready}, 64'd0);
    chk("rst_we", {63'b0, imem_we}, 64'd0);
    chk("rst_done", {63'b0, done}, 64'd0);
    chk("rst_word_count", 64'(word_count), 64'd0);
    chk("rst_overflow", {63'b0, overflow}, 64'd0);
    reset = 1'b0;
    for (int i = 0; i < 6; i++) do_load(tbl[i]);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data = 32'hdeadbeef;
    repeat (2) @(negedge clk);
    chk("mid_word_count", 64'(word_count), 64'd2);
    reset = 1'b1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    chk("midrst_cpu_reset", {63'b0, cpu_reset}, 64'd1);
    chk("midrst_ready", {63'b0, bus.in_ready}, 64'd0);
    chk("midrst_load_ins", {63'b0, load_ins}, 64'd0);
    chk("midrst_word_count", 64'(word_count), 64'd0);
    chk("midrst_we", {63'b0, imem_we}, 64'd0);
    do_load(tbl[0]);
    for (int k = 0; k < 20; k++) begin
      r.kind = 2;
      r.alt = 1'b0;
      r.pct = $urandom_range(30, 100);
      r.last_at = ($urandom_range(3) == 0) ? 0 : $urandom_range(1, DEPTH + 2);
      r.n = (r.last_at == 0) ? DEPTH + $urandom_range(0, 2) : r.last_at;
      model(r.last_at, r.exp_wc, r.exp_ovf);
      do_load(r);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
